instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the program ROM. It owns the program counter, drives the ROM address, captures the returned word into an instruction register, and presents it to decode over a valid/ready handshake. It also handles jump redirects with a pipeline flush, an external halt, and an out-of-range fault.

---
 rtl/instr_fetch.sv | 85 ++++++++
 tb/tb_instr_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational program ROM,
// and registers the returned word for decode over a valid/ready handshake.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_LIMIT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] rom_ad_o,
  input  logic [15:0] rom_data_i,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        jmp_i,
  input  logic [15:0] jmp_target_i,
  input  logic        halt_i,
  output logic        fault_o
);

  // 17 bits so that a limit of 65536 (full address space) never trips
  localparam logic [16:0] LIMIT = 17'(PC_LIMIT);

  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic slot;
  logic consume;
  logic pc_ok;
  logic fetch_try;

  assign slot      = !valid_q || instr_ready_i;
  assign consume   = valid_q && instr_ready_i;
  assign pc_ok     = {1'b0, pc_q} < LIMIT;
  assign fetch_try = slot && !halt_i && !fault_q;

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    if (jmp_i) begin
      pc_d    = jmp_target_i;
      valid_d = 1'b0;
    end else if (fetch_try && !pc_ok) begin
      // A word handed to decode on this edge must not be presented again
      fault_d = 1'b1;
      if (consume) valid_d = 1'b0;
    end else if (fetch_try) begin
      instr_d    = rom_data_i;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + 16'd1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign rom_ad_o      = pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of per-edge vectors checked through a queue,
// plus short sequences for a PC_LIMIT=4 fault case and a 16-bit PC wrap.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance: RESET_PC=0, PC_LIMIT=1024
  logic        rst, rdy, halt, jmp;
  logic [15:0] tgt, rom_ad, rom_data, instr, ipc;
  logic        valid, fault;
  assign rom_data = 16'h1000 + rom_ad;

  instr_fetch #(.RESET_PC(16'h0000), .PC_LIMIT(1024)) dut (
    .clk_i(clk), .rst_i(rst), .rom_ad_o(rom_ad), .rom_data_i(rom_data),
    .instr_o(instr), .instr_pc_o(ipc), .instr_valid_o(valid),
    .instr_ready_i(rdy), .jmp_i(jmp), .jmp_target_i(tgt), .halt_i(halt),
    .fault_o(fault));

  // auxiliary instances share one set of inputs
  logic        a_rst, a_rdy, a_jmp;
  logic [15:0] a_tgt;
  logic [15:0] f_ad, f_data, f_instr, f_ipc;
  logic        f_valid, f_fault;
  logic [15:0] w_ad, w_data, w_instr, w_ipc;
  logic        w_valid, w_fault;
  assign f_data = 16'h1000 + f_ad;
  assign w_data = 16'h1000 + w_ad;

  instr_fetch #(.RESET_PC(16'h0000), .PC_LIMIT(4)) dut_f (
    .clk_i(clk), .rst_i(a_rst), .rom_ad_o(f_ad), .rom_data_i(f_data),
    .instr_o(f_instr), .instr_pc_o(f_ipc), .instr_valid_o(f_valid),
    .instr_ready_i(a_rdy), .jmp_i(a_jmp), .jmp_target_i(a_tgt), .halt_i(1'b0),
    .fault_o(f_fault));

  instr_fetch #(.RESET_PC(16'hFFFE), .PC_LIMIT(65536)) dut_w (
    .clk_i(clk), .rst_i(a_rst), .rom_ad_o(w_ad), .rom_data_i(w_data),
    .instr_o(w_instr), .instr_pc_o(w_ipc), .instr_valid_o(w_valid),
    .instr_ready_i(a_rdy), .jmp_i(a_jmp), .jmp_target_i(a_tgt), .halt_i(1'b0),
    .fault_o(w_fault));

  typedef struct {
    logic        rst, rdy, halt, jmp;
    logic [15:0] tgt;
    logic        v;
    logic [15:0] ins, ipc, rad;
    logic        f;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic r, logic rd, logic h, logic j, logic [15:0] t,
                              logic v, logic [15:0] i, logic [15:0] p,
                              logic [15:0] a, logic f);
    vec_t x;
    x.rst = r; x.rdy = rd; x.halt = h; x.jmp = j; x.tgt = t;
    x.v = v; x.ins = i; x.ipc = p; x.rad = a; x.f = f;
    return x;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic aux_step(input logic r, input logic rd, input logic j, input logic [15:0] t);
    @(negedge clk);
    a_rst = r; a_rdy = rd; a_jmp = j; a_tgt = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; halt = 1'b0; jmp = 1'b0; tgt = 16'h0000;
    a_rst = 1'b1; a_rdy = 1'b0; a_jmp = 1'b0; a_tgt = 16'h0000;

    //                rst rdy hlt jmp tgt      v  instr    ipc      rom_ad   f
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1000, 16'h0000, 16'h0001, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1001, 16'h0001, 16'h0002, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1002, 16'h0002, 16'h0003, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1003, 16'h0003, 16'h0004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1003, 16'h0003, 16'h0004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1003, 16'h0003, 16'h0004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1003, 16'h0003, 16'h0004, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1004, 16'h0004, 16'h0005, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1005, 16'h0005, 16'h0006, 0));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0020, 0, 16'h1005, 16'h0005, 16'h0020, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1020, 16'h0020, 16'h0021, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h1020, 16'h0020, 16'h0021, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h1020, 16'h0020, 16'h0021, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h1020, 16'h0020, 16'h0021, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h1020, 16'h0020, 16'h0021, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1021, 16'h0021, 16'h0022, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 16'h1021, 16'h0021, 16'h0022, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1021, 16'h0021, 16'h0022, 0));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0300, 0, 16'h1021, 16'h0021, 16'h0300, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1300, 16'h0300, 16'h0301, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1300, 16'h0300, 16'h0301, 0));
    tbl.push_back(mk(1, 0, 0, 1, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1000, 16'h0000, 16'h0001, 0));
    tbl.push_back(mk(0, 0, 1, 1, 16'h03FF, 0, 16'h1000, 16'h0000, 16'h03FF, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h13FF, 16'h03FF, 16'h0400, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h13FF, 16'h03FF, 16'h0400, 1));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 0, 16'h13FF, 16'h03FF, 16'h0000, 1));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h13FF, 16'h03FF, 16'h0000, 1));
    tbl.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1000, 16'h0000, 16'h0001, 0));

    foreach (tbl[k]) begin
      vec_t e;
      @(negedge clk);
      rst = tbl[k].rst; rdy = tbl[k].rdy; halt = tbl[k].halt;
      jmp = tbl[k].jmp; tgt = tbl[k].tgt;
      sb.push_back(tbl[k]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: got 0 entries want 1 at vector %0d", k);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_valid", k), {15'd0, valid}, {15'd0, e.v});
        chk($sformatf("v%0d_instr", k), instr, e.ins);
        chk($sformatf("v%0d_ipc",   k), ipc,   e.ipc);
        chk($sformatf("v%0d_rom_ad", k), rom_ad, e.rad);
        chk($sformatf("v%0d_fault", k), {15'd0, fault}, {15'd0, e.f});
      end
    end

    // PC_LIMIT=4 fault sequence and RESET_PC=FFFE wrap, driven together
    aux_step(1, 1, 0, 16'h0000);
    chk("f_rst_ad", f_ad, 16'h0000);
    chk("w_rst_ad", w_ad, 16'hFFFE);
    chk("w_rst_valid", {15'd0, w_valid}, 16'h0000);
    aux_step(0, 1, 0, 16'h0000);
    chk("w_fetch_fffe", w_instr, 16'h0FFE);
    chk("w_ad_ffff", w_ad, 16'hFFFF);
    aux_step(0, 1, 0, 16'h0000);
    chk("w_ipc_ffff", w_ipc, 16'hFFFF);
    chk("w_wrap_ad", w_ad, 16'h0000);
    aux_step(0, 1, 0, 16'h0000);
    chk("w_after_wrap", w_instr, 16'h1000);
    chk("w_no_fault", {15'd0, w_fault}, 16'h0000);
    aux_step(0, 1, 0, 16'h0000);
    chk("f_ipc3", f_ipc, 16'h0003);
    chk("f_instr3", f_instr, 16'h1003);
    chk("f_not_yet", {15'd0, f_fault}, 16'h0000);
    aux_step(0, 1, 0, 16'h0000);
    chk("f_fault_set", {15'd0, f_fault}, 16'h0001);
    chk("f_drained", {15'd0, f_valid}, 16'h0000);
    chk("f_pc_held", f_ad, 16'h0004);
    aux_step(0, 1, 1, 16'h0000);
    chk("f_jmp_ad", f_ad, 16'h0000);
    aux_step(0, 1, 0, 16'h0000);
    chk("f_no_fetch_valid", {15'd0, f_valid}, 16'h0000);
    chk("f_no_fetch_ad", f_ad, 16'h0000);
    chk("f_sticky", {15'd0, f_fault}, 16'h0001);
    aux_step(1, 1, 0, 16'h0000);
    chk("f_rst_clears", {15'd0, f_fault}, 16'h0000);
    chk("w_rst_again_ad", w_ad, 16'hFFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
